configurable_transmitter: RTL and testbench

//  UART transmit serialiser, successor to the fixed 8N1 transmitter. Pops words from an upstream FIFO and shifts them out LSB-first.

---
 rtl/simple_uart_pkg.sv | 37 +++
 rtl/uart_baud_counter.sv | 29 ++
 rtl/configurable_transmitter.sv | 146 ++++++++++++++
 tb/tb_configurable_transmitter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/simple_uart_pkg.sv
// Shared UART types and helpers used by the transmitter (and later the receiver).
package simple_uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_EVEN = 2'd1,
    PARITY_ODD  = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_LOAD   = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
    ST_PARITY = 3'd5,
    ST_STOP   = 3'd6
  } tx_state_t;

  // A zero or oversized request falls back to the full word width.
  function automatic int unsigned decode_data_bits(input int unsigned raw,
                                                   input int unsigned max_bits);
    if (raw == 0 || raw > max_bits) begin
      return max_bits;
    end
    return raw;
  endfunction

  function automatic parity_t decode_parity(input logic [1:0] raw);
    case (raw)
      2'b01:   return PARITY_EVEN;
      2'b10:   return PARITY_ODD;
      default: return PARITY_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..div-1 while enabled and pulses bit_done on the last clock.
module uart_baud_counter #(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 enable,
  output logic                 bit_done
);

  logic [DIV_WIDTH-1:0] count_reg;
  logic                 last_clk;

  // Widened compare keeps div==1 and the all-ones divisor well defined.
  assign last_clk = ({1'b0, count_reg} + {{DIV_WIDTH{1'b0}}, 1'b1}) >= {1'b0, div};
  assign bit_done = enable && last_clk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (!enable || last_clk) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/configurable_transmitter.sv
// UART transmit serialiser with runtime data length, parity, stop bits and divisor.
module configurable_transmitter
  import simple_uart_pkg::*;
#(
  parameter logic [31:0] CLOCK_FREQUENCY = 32'd100_000_000,
  parameter logic [31:0] BAUD_RATE       = 32'd115200,
  parameter int unsigned WORD_WIDTH      = 32'd8,
  parameter int unsigned DIV_WIDTH       = 32'd16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [WORD_WIDTH-1:0]           din,
  input  logic                            empty,
  output logic                            re,
  output logic                            dout,
  input  logic [$clog2(WORD_WIDTH+1)-1:0] cfg_data_bits,
  input  logic [1:0]                      cfg_parity,
  input  logic                            cfg_two_stop,
  input  logic [DIV_WIDTH-1:0]            cfg_divisor,
  output logic                            busy
);

  localparam int CW = $clog2(WORD_WIDTH + 1);
  localparam logic [31:0] DEFAULT_DIV_FULL = CLOCK_FREQUENCY / BAUD_RATE;
  localparam logic [DIV_WIDTH-1:0] DEFAULT_DIV = DEFAULT_DIV_FULL[DIV_WIDTH-1:0];

  tx_state_t             state_reg;
  logic [WORD_WIDTH-1:0] data_reg;
  logic [CW-1:0]         bit_idx_reg;
  logic [CW-1:0]         nbits_reg;
  logic                  par_en_reg;
  logic                  par_bit_reg;
  logic                  two_stop_reg;
  logic                  stop_idx_reg;
  logic [DIV_WIDTH-1:0]  div_reg;

  logic [CW-1:0]         nbits_eff;
  logic [WORD_WIDTH-1:0] din_masked;
  parity_t               parity_sel;
  logic                  baud_en;
  logic                  bit_done;

  assign nbits_eff  = CW'(decode_data_bits(32'(cfg_data_bits), WORD_WIDTH));
  assign parity_sel = decode_parity(cfg_parity);

  // Bits above the configured length are dropped before parity is formed.
  genvar gi;
  generate
    for (gi = 0; gi < WORD_WIDTH; gi++) begin : g_mask
      assign din_masked[gi] = din[gi] & (nbits_eff > CW'(gi));
    end
  endgenerate

  assign baud_en = (state_reg == ST_START) || (state_reg == ST_DATA) ||
                   (state_reg == ST_PARITY) || (state_reg == ST_STOP);

  uart_baud_counter #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .div      (div_reg),
    .enable   (baud_en),
    .bit_done (bit_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      data_reg     <= '0;
      bit_idx_reg  <= '0;
      nbits_reg    <= '0;
      par_en_reg   <= 1'b0;
      par_bit_reg  <= 1'b0;
      two_stop_reg <= 1'b0;
      stop_idx_reg <= 1'b0;
      div_reg      <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (!empty) begin
            state_reg <= ST_READ;
          end
        end
        ST_READ: begin
          state_reg <= ST_LOAD;
        end
        ST_LOAD: begin
          data_reg     <= din_masked;
          nbits_reg    <= nbits_eff;
          par_en_reg   <= (parity_sel != PARITY_NONE);
          par_bit_reg  <= (parity_sel == PARITY_ODD) ? ~^din_masked : ^din_masked;
          two_stop_reg <= cfg_two_stop;
          div_reg      <= (cfg_divisor == '0) ? DEFAULT_DIV : cfg_divisor;
          bit_idx_reg  <= '0;
          stop_idx_reg <= 1'b0;
          state_reg    <= ST_START;
        end
        ST_START: begin
          if (bit_done) begin
            state_reg <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_done) begin
            data_reg <= data_reg >> 1;
            if (bit_idx_reg == nbits_reg - CW'(1)) begin
              state_reg <= par_en_reg ? ST_PARITY : ST_STOP;
            end else begin
              bit_idx_reg <= bit_idx_reg + CW'(1);
            end
          end
        end
        ST_PARITY: begin
          if (bit_done) begin
            state_reg <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (bit_done) begin
            if (two_stop_reg && !stop_idx_reg) begin
              stop_idx_reg <= 1'b1;
            end else begin
              state_reg <= ST_IDLE;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    dout = 1'b1;
    case (state_reg)
      ST_START:  dout = 1'b0;
      ST_DATA:   dout = data_reg[0];
      ST_PARITY: dout = par_bit_reg;
      default:   dout = 1'b1;
    endcase
  end

  assign re   = (state_reg == ST_READ);
  assign busy = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_configurable_transmitter.sv
// Randomised bench for configurable_transmitter against a frame-level model.
module tb_configurable_transmitter;

  localparam int W   = 8;
  localparam int CW  = $clog2(W + 1);
  localparam int DEF = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  din = '0;
  logic          empty = 1'b1;
  logic          re;
  logic          dout;
  logic [CW-1:0] cfg_data_bits = '0;
  logic [1:0]    cfg_parity = 2'b00;
  logic          cfg_two_stop = 1'b0;
  logic [15:0]   cfg_divisor = '0;
  logic          busy;

  configurable_transmitter #(
    .CLOCK_FREQUENCY (32'd400),
    .BAUD_RATE       (32'd100),
    .WORD_WIDTH      (32'd8),
    .DIV_WIDTH       (32'd16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .din           (din),
    .empty         (empty),
    .re            (re),
    .dout          (dout),
    .cfg_data_bits (cfg_data_bits),
    .cfg_parity    (cfg_parity),
    .cfg_two_stop  (cfg_two_stop),
    .cfg_divisor   (cfg_divisor),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit re;
    bit dout;
    bit busy;
    int kind;   // 0 plain, 1 read cycle, 2 load cycle
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] fifo_q[$];
  logic [W-1:0] model_q[$];
  logic [W-1:0] cur_word;
  bit           log_q[$];
  bit           prev_busy = 1'b0;
  int           re_cnt = 0;
  int           total = 0;
  int           bad = 0;

  task automatic check(input string name, input bit er, input bit ed, input bit eb);
    total++;
    if (re !== er || dout !== ed || busy !== eb) begin
      bad++;
      $display("FAIL %s t=%0t re/dout/busy got %b%b%b want %b%b%b",
               name, $time, re, dout, busy, er, ed, eb);
    end
  endtask

  task automatic push_exp(input bit r, input bit d, input bit b, input int k);
    exp_t e;
    e.re = r; e.dout = d; e.busy = b; e.kind = k;
    exp_q.push_back(e);
  endtask

  // Frame expectations from the serial-line rules, using config seen in the LOAD cycle.
  task automatic build_frame(input logic [W-1:0] word);
    int n, d, ones;
    bit bits[$];
    n = (cfg_data_bits == 0 || cfg_data_bits > W) ? W : int'(cfg_data_bits);
    d = (cfg_divisor == 0) ? DEF : int'(cfg_divisor);
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      bits.push_back(word[i]);
      ones += int'(word[i]);
    end
    if (cfg_parity == 2'b01) bits.push_back(ones % 2 == 1);
    if (cfg_parity == 2'b10) bits.push_back(ones % 2 == 0);
    bits.push_back(1'b1);
    if (cfg_two_stop) bits.push_back(1'b1);
    foreach (bits[i]) begin
      for (int k = 0; k < d; k++) push_exp(1'b0, bits[i], 1'b1, 0);
    end
  endtask

  task automatic model_step();
    exp_t e;
    if (rst) begin
      exp_q.delete();
      check("reset", 1'b0, 1'b1, 1'b0);
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("frame", e.re, e.dout, e.busy);
      if (e.kind == 1) begin
        if (model_q.size() > 0) cur_word = model_q.pop_front();
      end
      if (e.kind == 2) build_frame(cur_word);
    end else begin
      check("idle", 1'b0, 1'b1, 1'b0);
      if (!empty) begin
        push_exp(1'b1, 1'b1, 1'b1, 1);
        push_exp(1'b0, 1'b1, 1'b1, 2);
      end
    end
    if (re === 1'b1) begin
      re_cnt++;
      if (fifo_q.size() > 0) din = fifo_q.pop_front();
      empty = (fifo_q.size() == 0);
    end
    if (busy === 1'b1 && !prev_busy) log_q.delete();
    if (busy === 1'b1) log_q.push_back(dout);
    if (busy !== 1'b1 && prev_busy) $display("frame done t=%0t busy_clks=%0d", $time, log_q.size());
    prev_busy = (busy === 1'b1);
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [W-1:0] w);
    fifo_q.push_back(w);
    model_q.push_back(w);
    empty = 1'b0;
  endtask

  task automatic set_cfg(input int nb, input int par, input bit two, input int dv);
    cfg_data_bits = CW'(nb);
    cfg_parity    = 2'(par);
    cfg_two_stop  = two;
    cfg_divisor   = 16'(dv);
  endtask

  task automatic rand_cfg();
    set_cfg($urandom_range(0, 15), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
            $urandom_range(0, 5));
  endtask

  task automatic wait_drain(input string name, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && fifo_q.size() == 0 && !prev_busy) break;
      tick();
    end
    total++;
    if (i >= budget) begin
      bad++;
      $display("FAIL %s drain timeout after %0d clks, want idle", name, budget);
    end
    repeat (3) tick();
  endtask

  // Compare the logged busy window against READ, LOAD and hand-listed bits of div clocks each.
  task automatic check_log(input string name, input bit bits[$], input int d);
    bit want[$];
    bit ok;
    want.push_back(1'b1);
    want.push_back(1'b1);
    foreach (bits[i]) for (int k = 0; k < d; k++) want.push_back(bits[i]);
    ok = (want.size() == log_q.size());
    if (ok) foreach (want[i]) if (want[i] != log_q[i]) ok = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s frame trace got len=%0d want len=%0d or bit values differ",
               name, log_q.size(), want.size());
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  initial begin
    bit b1[$], b2[$], b3[$];
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (3) tick();

    // 8N1 default divisor, A5
    set_cfg(8, 0, 1'b0, 0);
    push_word(8'hA5);
    wait_drain("8n1", 500);
    b1 = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    check_log("8n1_a5", b1, 4);

    // 7E2 div 3, 83
    set_cfg(7, 1, 1'b1, 3);
    push_word(8'h83);
    wait_drain("7e2", 500);
    b2 = '{0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1};
    check_log("7e2_83", b2, 3);
    check_int("7e2_busy_clks", log_q.size(), 35);

    // 5O1 div 1, 1F
    set_cfg(5, 2, 1'b0, 1);
    push_word(8'h1F);
    wait_drain("5o1", 500);
    b3 = '{0, 1, 1, 1, 1, 1, 0, 1};
    check_log("5o1_1f", b3, 1);

    // three queued words back to back
    set_cfg(8, 0, 1'b0, 2);
    re_cnt = 0;
    push_word(8'h11); push_word(8'h22); push_word(8'h33);
    wait_drain("burst3", 1000);
    repeat (10) tick();
    check_int("burst3_re_pulses", re_cnt, 3);

    // config changes mid-frame apply only to the next frame
    set_cfg(8, 0, 1'b0, 4);
    push_word(8'h5C);
    repeat (14) tick();
    set_cfg(6, 1, 1'b1, 2);
    push_word(8'hC3);
    wait_drain("midcfg", 1000);

    // reset in the middle of the data bits
    set_cfg(8, 0, 1'b0, 4);
    push_word(8'hF0);
    repeat (10) tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    re_cnt = 0;
    repeat (20) tick();
    check_int("post_reset_no_re", re_cnt, 0);

    // randomised frames with occasional config churn
    for (int it = 0; it < 25; it++) begin
      int n, c;
      rand_cfg();
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) push_word(W'($urandom));
      for (c = 0; c < 1500; c++) begin
        if (exp_q.size() == 0 && fifo_q.size() == 0 && !prev_busy) break;
        if ($urandom_range(0, 7) == 0) rand_cfg();
        tick();
      end
      wait_drain("random", 1500);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
